// File: rtl/fwd_pkg.sv
// Shared types and helpers for the forwarding/hazard scoreboard.
// FWD_FLOAT_EN selects whether the FP register-file bit takes part in tag matching.
package fwd_pkg;

    localparam int REG_W     = 5;
    localparam int MAX_DEPTH = 7;
    localparam int CNT_W     = 3;

`ifdef FWD_FLOAT_EN
    localparam bit FP_EN = 1'b1;
`else
    localparam bit FP_EN = 1'b0;
`endif

    typedef struct packed {
        logic             valid;
        logic             fp;
        logic [REG_W-1:0] rd;
        logic [CNT_W-1:0] cnt;
    } slot_t;

    // Returns (lowest set index + 1), or 0 when nothing hits; slot 0 is the youngest.
    function automatic logic [CNT_W-1:0] youngest_hit(input logic [MAX_DEPTH-1:0] hits);
        youngest_hit = '0;
        for (int i = MAX_DEPTH - 1; i >= 0; i--) begin
            if (hits[i]) youngest_hit = CNT_W'(i + 1);
        end
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Purpose: per-operand youngest-writer match producing a bypass select and a pending flag.
// Latency: purely combinational from slot state and source inputs.
// Backpressure: none; pending feeds the ID stall request in the top.
module fwd_match
    import fwd_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int SELW  = $clog2(DEPTH + 1)
) (
    input  slot_t [DEPTH-1:0] slots,
    input  logic [REG_W-1:0]  src_reg,
    input  logic              src_fp,
    input  logic              src_used,
    output logic [SELW-1:0]   sel,
    output logic              pending
);

    logic [MAX_DEPTH-1:0] hits;
    logic [CNT_W-1:0]     idx;
    logic [CNT_W-1:0]     ycnt;
    logic                 src_fp_eff;

    assign src_fp_eff = src_fp & FP_EN;

    always_comb begin
        hits = '0;
        for (int k = 0; k < DEPTH; k++) begin
            hits[k] = src_used && slots[k].valid &&
                      (slots[k].fp == src_fp_eff) && (slots[k].rd == src_reg);
        end
    end

    assign idx = youngest_hit(hits);

    // Remaining latency of the youngest matching writer; older matches are shadowed.
    always_comb begin
        ycnt = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (idx == CNT_W'(k + 1)) ycnt = slots[k].cnt;
        end
    end

    assign pending = (idx != '0) && (ycnt != '0);
    assign sel     = ((idx != '0) && (ycnt == '0)) ? SELW'(idx) : '0;

endmodule

// File: rtl/fwd_scoreboard.sv
// Purpose: DEPTH-stage writer tracker driving per-source bypass selects and an ID stall (FWD_FLOAT_EN adds FP tags).
// Latency: selects/hazard combinational from state; state and stall_cnt update on the clk edge.
// Backpressure: hazard requests an ID stall; advance=0 freezes all slots, flush empties them.
module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter  int DEPTH = 3,
    parameter  int NSRC  = 3,
    localparam int SELW  = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   advance,
    input  logic                   flush,
    input  logic                   issue_valid,
    input  logic [REG_W-1:0]       issue_rd,
    input  logic                   issue_rd_fp,
    input  logic                   issue_wb,
    input  logic [SELW-1:0]        issue_lat,
    input  logic [NSRC*REG_W-1:0]  src_reg,
    input  logic [NSRC-1:0]        src_fp,
    input  logic [NSRC-1:0]        src_used,
    output logic [NSRC*SELW-1:0]   fwd_sel,
    output logic                   hazard,
    output logic [31:0]            stall_cnt
);

    slot_t [DEPTH-1:0] slots;
    slot_t [DEPTH-1:0] shifted;
    slot_t             new_slot;
    logic [NSRC-1:0]   pending;
    logic              issue_fp_eff;
    logic [CNT_W-1:0]  lat_clamp;

    assign issue_fp_eff = issue_rd_fp & FP_EN;
    assign lat_clamp    = (int'(issue_lat) > DEPTH - 1) ? CNT_W'(DEPTH - 1) : CNT_W'(issue_lat);

    // Integer x0 is never marked valid, so it can never be matched.
    always_comb begin
        new_slot       = '0;
        new_slot.valid = issue_valid && issue_wb && (issue_fp_eff || (issue_rd != '0));
        new_slot.fp    = issue_fp_eff;
        new_slot.rd    = issue_rd;
        new_slot.cnt   = lat_clamp;
    end

    always_comb begin
        shifted    = '0;
        shifted[0] = new_slot;
        for (int k = 1; k < DEPTH; k++) begin
            shifted[k] = slots[k-1];
            if (slots[k-1].cnt != '0) shifted[k].cnt = slots[k-1].cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slots     <= '0;
            stall_cnt <= '0;
        end else begin
            if (hazard && (stall_cnt != 32'hFFFF_FFFF)) stall_cnt <= stall_cnt + 32'd1;
            if (flush) begin
                slots <= '0;
            end else if (advance) begin
                slots <= shifted;
            end
        end
    end

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        fwd_match #(
            .DEPTH (DEPTH),
            .SELW  (SELW)
        ) u_match (
            .slots    (slots),
            .src_reg  (src_reg[REG_W*i +: REG_W]),
            .src_fp   (src_fp[i]),
            .src_used (src_used[i]),
            .sel      (fwd_sel[SELW*i +: SELW]),
            .pending  (pending[i])
        );
    end

    assign hazard = |pending;

endmodule
